// File: rtl/prism_cfg_pkg.sv
// Shared definitions for the PRISM config register front end:
// register offsets, loader word addresses, TinyQV write-size encodings,
// the send FSM state type and a helper that turns a byte offset into a
// register index (address[5:2]).
package prism_cfg_pkg;

    // Register byte offsets inside the 64-byte peripheral window.
    localparam logic [5:0] CFG_LO_OFS = 6'd0;
    localparam logic [5:0] CFG_HI_OFS = 6'd4;
    localparam logic [5:0] STATUS_OFS = 6'd8;
    localparam logic [5:0] CTRL_OFS   = 6'd12;

    // Word addresses presented to the latch loader.
    localparam logic [2:0] LD_ADDR_LO = 3'h0;
    localparam logic [2:0] LD_ADDR_HI = 3'h4;

    // TinyQV data_write_n / data_read_n encodings.
    localparam logic [1:0] WR_BYTE = 2'b00;
    localparam logic [1:0] WR_HALF = 2'b01;
    localparam logic [1:0] WR_WORD = 2'b10;
    localparam logic [1:0] WR_IDLE = 2'b11;
    localparam logic [1:0] RD_IDLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2,
        BUSY    = 2'd3
    } state_t;

    function automatic logic [3:0] reg_index(input logic [5:0] ofs);
        return ofs[5:2];
    endfunction

endpackage

// File: rtl/prism_cfg_regif_cfg_word_merge.sv
// cfg_word_merge: combinational lane merge of a TinyQV write into a 32-bit
// register value.
//   cur      in  32  current register contents
//   data_in  in  32  CPU write data (byte in [7:0], half in [15:0])
//   size     in  2   data_write_n encoding
//   lane     in  2   address[1:0] of the access
//   merged   out 32  register value after the write
module cfg_word_merge
    import prism_cfg_pkg::*;
(
    input  logic [31:0] cur,
    input  logic [31:0] data_in,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        merged = cur;
        case (size)
            WR_BYTE: merged[{lane, 3'b000} +: 8] = data_in[7:0];
            WR_HALF: merged[{lane[1], 4'b0000} +: 16] = data_in[15:0];
            WR_WORD: merged = data_in;
            default: merged = cur;
        endcase
    end

endmodule

// File: rtl/prism_cfg_regif.sv
// prism_cfg_regif: TinyQV register front end for the PRISM config latch
// array. CPU writes build a 64-bit staging image (CFG_LO/CFG_HI); a commit
// copies it to a send buffer and pushes LO then HI to the loader, then
// waits out the loader's shift time before accepting the next image. One
// commit may be held pending; further commits or staging writes while it
// is held set the sticky overrun flag.
//   clk, rst_n    clock, asynchronous active-low reset
//   address       byte address (register index in [5:2])
//   data_in       CPU write data
//   data_write_n  11 idle, 00 byte, 01 half, 10 word
//   data_read_n   11 idle, anything else reads
//   data_out      registered read data, valid with data_ready
//   data_ready    one-cycle read strobe
//   ld_write_req  loader write strobe (SEND_LO / SEND_HI only)
//   ld_address    loader word address, 0 when idle
//   ld_data       loader word, 0 when idle
//   irq_done      one-cycle pulse when the busy countdown expires
module prism_cfg_regif
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        ld_write_req,
    output logic [2:0]  ld_address,
    output logic [31:0] ld_data,
    output logic        irq_done
);

    localparam logic [31:0] HI_MASK = 32'hFFFF_FFFF >> (64 - WIDTH);
    localparam int CNT_W = $clog2(2 * DEPTH + 2);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(2 * DEPTH + 1);

    localparam logic [3:0] SEL_LO     = reg_index(CFG_LO_OFS);
    localparam logic [3:0] SEL_HI     = reg_index(CFG_HI_OFS);
    localparam logic [3:0] SEL_STATUS = reg_index(STATUS_OFS);
    localparam logic [3:0] SEL_CTRL   = reg_index(CTRL_OFS);

    state_t             state, state_nxt;
    logic [31:0]        stage_lo, stage_hi;
    logic [31:0]        buf_lo, buf_hi;
    logic [CNT_W-1:0]   busy_cnt;
    logic [7:0]         commit_cnt;
    logic               pending, ovr;

    logic [3:0]  sel;
    logic        wr_any, rd_any, wr_lo, wr_hi, wr_ctrl, ctrl_lane0;
    logic        commit, clr_ovr, expire, not_idle, launch, ovr_set;
    logic [31:0] lo_merged, hi_merged, stage_lo_nxt, stage_hi_nxt;
    logic [31:0] rd_mux;

    assign sel      = address[5:2];
    assign wr_any   = (data_write_n != WR_IDLE);
    assign rd_any   = (data_read_n != RD_IDLE);
    assign wr_lo    = wr_any && (sel == SEL_LO);
    assign wr_hi    = wr_any && (sel == SEL_HI);
    assign wr_ctrl  = wr_any && (sel == SEL_CTRL);
    assign not_idle = (state != IDLE);
    assign expire   = (state == BUSY) && (busy_cnt == '0);

    cfg_word_merge u_merge_lo (
        .cur     (stage_lo),
        .data_in (data_in),
        .size    (data_write_n),
        .lane    (address[1:0]),
        .merged  (lo_merged)
    );

    cfg_word_merge u_merge_hi (
        .cur     (stage_hi),
        .data_in (data_in),
        .size    (data_write_n),
        .lane    (address[1:0]),
        .merged  (hi_merged)
    );

    // Staging is frozen while a commit is pending.
    assign stage_lo_nxt = (wr_lo && !pending) ? lo_merged : stage_lo;
    assign stage_hi_nxt = (wr_hi && !pending) ? (hi_merged & HI_MASK) : stage_hi;

    // CTRL bits live in byte lane 0; only accesses covering that lane act.
    assign ctrl_lane0 = (data_write_n == WR_WORD)
                     || ((data_write_n == WR_HALF) && !address[1])
                     || ((data_write_n == WR_BYTE) && (address[1:0] == 2'b00));

    assign commit  = (wr_hi && (data_write_n == WR_WORD))
                  || (wr_ctrl && ctrl_lane0 && data_in[0]);
    assign clr_ovr = wr_ctrl && ctrl_lane0 && data_in[1];

    // A commit while not idle with one already pending, or any staging write
    // while pending, is an overrun.
    assign ovr_set = (commit && not_idle && pending) || ((wr_lo || wr_hi) && pending);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and loader-side outputs.
    always_comb begin
        state_nxt    = state;
        launch       = 1'b0;
        ld_write_req = 1'b0;
        ld_address   = '0;
        ld_data      = '0;
        irq_done     = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    launch    = 1'b1;
                    state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                ld_write_req = 1'b1;
                ld_address   = LD_ADDR_LO;
                ld_data      = buf_lo;
                state_nxt    = SEND_HI;
            end
            SEND_HI: begin
                ld_write_req = 1'b1;
                ld_address   = LD_ADDR_HI;
                ld_data      = buf_hi;
                state_nxt    = BUSY;
            end
            BUSY: begin
                if (busy_cnt == '0) begin
                    irq_done = 1'b1;
                    // A commit landing on the expiry cycle counts as pending
                    // and is served straight away by the same relaunch.
                    if (pending || commit) begin
                        launch    = 1'b1;
                        state_nxt = SEND_LO;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Staging, send buffer, pending/overrun and counters.
    // NOTE: every flop here has an async reset; a reset mid-send discards the
    // image, so nothing may survive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_lo   <= '0;
            stage_hi   <= '0;
            buf_lo     <= '0;
            buf_hi     <= '0;
            busy_cnt   <= '0;
            commit_cnt <= '0;
            pending    <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            stage_lo <= stage_lo_nxt;
            stage_hi <= stage_hi_nxt;

            if (launch) begin
                buf_lo <= stage_lo_nxt;
                buf_hi <= stage_hi_nxt;
            end

            if (expire && pending)
                pending <= 1'b0;
            else if (commit && not_idle && !pending && !expire)
                pending <= 1'b1;

            // Setting beats clearing when both happen in one write.
            if (ovr_set)      ovr <= 1'b1;
            else if (clr_ovr) ovr <= 1'b0;

            if (state == SEND_HI) begin
                busy_cnt   <= BUSY_LOAD;
                commit_cnt <= commit_cnt + 8'd1;
            end else if ((state == BUSY) && (busy_cnt != '0)) begin
                busy_cnt <= busy_cnt - 1'b1;
            end
        end
    end

    // Read mux samples pre-write register values.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_LO:     rd_mux = stage_lo;
            SEL_HI:     rd_mux = stage_hi;
            SEL_STATUS: rd_mux = {16'h0, commit_cnt, 5'h0, ovr, pending, not_idle};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_ready <= 1'b0;
        end else begin
            data_ready <= rd_any;
            data_out   <= rd_any ? rd_mux : '0;
        end
    end

endmodule
